// File: rtl/instr_encoder_pkg.sv
// ============================================================================
// Module   : enc_pkg
// Brief    : Shared widths, FIFO depth and FSM state type for instr_encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package enc_pkg;

  localparam int OP_W       = 8;
  localparam int IR_W       = 16;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 9;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Opcode in the high byte so the ID stage can split it back out unchanged.
  function automatic logic [IR_W-1:0] encode_instr(input logic [OP_W-1:0] code,
                                                   input logic [OP_W-1:0] value);
    return {code, value};
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_if.sv
// ============================================================================
// Module   : instr_encoder_if
// Brief    : Session control, opcode handshake and memory write bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_encoder_if;
  import enc_pkg::*;

  logic              halt_program;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        length;
  logic              op_valid;
  logic              op_ready;
  logic [OP_W-1:0]   op_code;
  logic [OP_W-1:0]   op_value;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [IR_W-1:0]   mem_wdata;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output halt_program, start, base_addr, length, op_valid, op_code, op_value,
    input  op_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow
  );

  modport slave (
    input  halt_program, start, base_addr, length, op_valid, op_code, op_value,
    output op_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow
  );

endinterface

`default_nettype wire

// File: rtl/instr_fifo.sv
// ============================================================================
// Module   : instr_fifo
// Brief    : Small synchronous FIFO; simultaneous push and pop allowed.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)
        r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)
        r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push)
        r_count <= r_count - 1'b1;
    end
  end

  // Storage is datapath only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs opcode/value pairs into 16-bit words and writes them to
//            consecutive instruction-memory addresses through a 4-deep FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_encoder
  import enc_pkg::*;
(
  input wire logic      clk,
  input wire logic      rst,
  instr_encoder_if.slave bus
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_wr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [IR_W-1:0]   r_mem_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;

  logic              w_ready;
  logic              w_accept;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [IR_W-1:0]   w_fifo_rdata;
  logic              w_in_session;

  assign w_in_session = (r_state == S_ACTIVE) || (r_state == S_DRAIN);
  assign w_ready      = (r_state == S_ACTIVE) && !w_fifo_full && (r_acc < r_len)
                        && !bus.halt_program;
  assign w_accept     = w_ready && bus.op_valid;
  assign w_pop        = w_in_session && !w_fifo_empty && !bus.halt_program;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_wdata (encode_instr(bus.op_code, bus.op_value)),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_acc       <= '0;
      r_wr        <= '0;
      r_wr_addr   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (!bus.halt_program) begin
      r_mem_we <= w_pop;
      if (w_pop) begin
        r_mem_addr  <= r_wr_addr;
        r_mem_wdata <= w_fifo_rdata;
        r_wr_addr   <= r_wr_addr + 1'b1;
        r_wr        <= r_wr + 1'b1;
        // Address 0 reached after at least one earlier write means we wrapped.
        if ((r_wr != '0) && (r_wr_addr == '0))
          r_overflow <= 1'b1;
      end
      if (w_accept)
        r_acc <= r_acc + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_wr_addr  <= bus.base_addr;
            r_len      <= {1'b0, bus.length};
            r_acc      <= '0;
            r_wr       <= '0;
            r_overflow <= 1'b0;
            if (bus.length == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ACTIVE;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (w_accept && (r_acc + 9'd1 == r_len))
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && (r_wr + 9'd1 == r_len)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A write registered just before a halt stays pending and is shown once
  // halt_program drops, so nothing is lost or duplicated.
  assign bus.mem_we    = r_mem_we && !bus.halt_program;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.op_ready  = w_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Directed bench with a queue-level reference model for instr_encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if u_if ();

  instr_encoder u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_cnt = 0;
  logic [23:0] wlog [$];
  int          wcyc [$];

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: session phase, pair queue and predicted write outputs.
  int          m_phase;   // 0 idle, 1 accepting, 2 draining, 3 done
  logic [7:0]  m_base;
  int          m_len, m_acc, m_wr;
  logic [15:0] m_q [$];
  bit          m_we, m_ovf;
  logic [7:0]  m_addr;
  logic [15:0] m_data;

  always @(negedge clk) begin
    bit exp_ready, acc_now, nwe;
    cyc++;
    if (!rst) begin
      m_phase = 0; m_base = '0; m_len = 0; m_acc = 0; m_wr = 0;
      m_q.delete(); m_we = 0; m_ovf = 0; m_addr = '0; m_data = '0;
    end
    exp_ready = (m_phase == 1) && (m_q.size() < 4) && (m_acc < m_len) && !u_if.halt_program;
    lit("mem_we",    u_if.mem_we,    m_we && !u_if.halt_program);
    lit("mem_addr",  u_if.mem_addr,  m_addr);
    lit("mem_wdata", u_if.mem_wdata, m_data);
    lit("overflow",  u_if.overflow,  m_ovf);
    lit("busy",      u_if.busy,      (m_phase == 1) || (m_phase == 2));
    lit("done",      u_if.done,      m_phase == 3);
    lit("op_ready",  u_if.op_ready,  exp_ready);
    if (u_if.mem_we === 1'b1) begin
      wlog.push_back({u_if.mem_addr, u_if.mem_wdata});
      wcyc.push_back(cyc);
    end
    if (u_if.done === 1'b1) done_cnt++;

    if (rst && !u_if.halt_program) begin
      acc_now = exp_ready && u_if.op_valid;
      nwe = 0;
      case (m_phase)
        0: if (u_if.start) begin
             m_base = u_if.base_addr; m_len = int'(u_if.length);
             m_acc = 0; m_wr = 0; m_ovf = 0;
             m_phase = (u_if.length == 0) ? 3 : 1;
           end
        1, 2: begin
             if (m_q.size() > 0) begin
               m_addr = 8'(m_base + m_wr);
               m_data = m_q.pop_front();
               nwe = 1;
               if (m_wr > 0 && m_addr == 0) m_ovf = 1;
               m_wr++;
             end
             if (acc_now) begin
               m_q.push_back({u_if.op_code, u_if.op_value});
               m_acc++;
             end
             if (m_phase == 1 && m_acc == m_len) m_phase = 2;
             else if (m_phase == 2 && m_wr == m_len) m_phase = 3;
           end
        default: m_phase = 0;
      endcase
      m_we = nwe;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic session(input logic [7:0] b, input logic [7:0] l, input int halt_at,
                         input int halt_n, input int restart_at);
    int idx = 0;
    int guard = 0;
    int d0 = done_cnt;
    bit hdone = 0, sdone = 0, acc;
    wlog.delete(); wcyc.delete();
    u_if.base_addr = b; u_if.length = l; u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    while (done_cnt == d0 && guard < 300) begin
      u_if.op_valid = (idx < int'(l));
      u_if.op_code  = 8'(idx + 1);
      u_if.op_value = 8'(8'hAA + 8'h11 * idx);
      if (!hdone && halt_at >= 0 && idx == halt_at) begin
        u_if.halt_program = 1'b1;
        repeat (halt_n) begin
          @(negedge clk);
          lit("halt_op_ready", u_if.op_ready, 1'b0);
          lit("halt_mem_we",   u_if.mem_we,   1'b0);
          step();
        end
        u_if.halt_program = 1'b0;
        hdone = 1;
      end
      if (!sdone && restart_at >= 0 && idx == restart_at) begin
        u_if.start = 1'b1; u_if.base_addr = 8'h40; sdone = 1;
      end
      @(negedge clk);
      acc = u_if.op_valid && u_if.op_ready;
      step();
      u_if.start = 1'b0;
      if (acc) idx++;
      guard++;
    end
    u_if.op_valid = 1'b0;
    lit("session_timeout", guard < 300, 1'b1);
  endtask

  initial begin
    int d0, we_cnt, idx, guard;
    bit acc;
    logic [23:0] basic_exp [3];
    basic_exp[0] = 24'h10_01AA; basic_exp[1] = 24'h11_02BB; basic_exp[2] = 24'h12_03CC;

    u_if.halt_program = 1'b0; u_if.start = 1'b0; u_if.base_addr = '0; u_if.length = '0;
    u_if.op_valid = 1'b0; u_if.op_code = '0; u_if.op_value = '0;
    repeat (2) step();
    lit("rst_mem_we", u_if.mem_we, 1'b0);
    lit("rst_busy", u_if.busy, 1'b0);
    lit("rst_ready", u_if.op_ready, 1'b0);
    rst = 1'b1;
    step();

    // Basic three-word session.
    d0 = done_cnt;
    session(8'h10, 8'd3, -1, 0, -1);
    lit("basic_count", wlog.size(), 3);
    for (int i = 0; i < 3; i++) lit("basic_word", wlog[i], basic_exp[i]);
    lit("basic_back_to_back", wcyc[2] - wcyc[0], 2);
    lit("basic_done_once", done_cnt - d0, 1);
    step();
    lit("basic_busy_low", u_if.busy, 1'b0);

    // Address wrap.
    session(8'hFE, 8'd3, -1, 0, -1);
    lit("wrap_a0", wlog[0][23:16], 8'hFE);
    lit("wrap_a1", wlog[1][23:16], 8'hFF);
    lit("wrap_a2", wlog[2][23:16], 8'h00);
    lit("wrap_overflow", u_if.overflow, 1'b1);

    // Zero length; also clears overflow from the wrap.
    wlog.delete();
    u_if.base_addr = 8'h77; u_if.length = 8'd0; u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    @(negedge clk);
    lit("zero_done_cycle2", u_if.done, 1'b1);
    lit("zero_busy", u_if.busy, 1'b0);
    lit("zero_ovf_cleared", u_if.overflow, 1'b0);
    step();
    @(negedge clk);
    lit("zero_done_once", u_if.done, 1'b0);
    step();
    lit("zero_no_writes", wlog.size(), 0);

    // Backpressure via halt_program.
    session(8'h20, 8'd8, 3, 5, -1);
    lit("bp_count", wlog.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < wlog.size())
        lit("bp_word", wlog[i], {8'(8'h20 + i), 8'(i + 1), 8'(8'hAA + 8'h11 * i)});

    // Start pulse during an active session is ignored.
    session(8'h30, 8'd4, -1, 0, 1);
    lit("ign_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size()) lit("ign_addr", wlog[i][23:16], 8'(8'h30 + i));

    // Reset mid-session after two accepts.
    u_if.base_addr = 8'h50; u_if.length = 8'd6; u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    idx = 0; guard = 0;
    while (idx < 2 && guard < 50) begin
      u_if.op_valid = 1'b1; u_if.op_code = 8'(idx + 1); u_if.op_value = 8'(idx + 8'h60);
      @(negedge clk);
      acc = u_if.op_ready;
      step();
      if (acc) idx++;
      guard++;
    end
    lit("rst_accepts_timeout", guard < 50, 1'b1);
    rst = 1'b0;
    #1;
    lit("mid_rst_we", u_if.mem_we, 1'b0);
    lit("mid_rst_addr", u_if.mem_addr, 8'h00);
    lit("mid_rst_wdata", u_if.mem_wdata, 16'h0000);
    lit("mid_rst_busy", u_if.busy, 1'b0);
    lit("mid_rst_done", u_if.done, 1'b0);
    lit("mid_rst_ovf", u_if.overflow, 1'b0);
    lit("mid_rst_ready", u_if.op_ready, 1'b0);
    step();
    rst = 1'b1;
    we_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (u_if.mem_we === 1'b1) we_cnt++;
      step();
    end
    lit("post_rst_no_we", we_cnt, 0);
    u_if.op_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst; no other clock or reset inputs.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- halt_program  in  1  freeze all state while high
- start  in  1  single-cycle pulse; begins a load session
- base_addr  in  8  first instruction-memory address of the session
- length  in  8  number of instructions in the session
- op_valid  in  1  producer has an opcode/value pair
- op_ready  out  1  encoder accepts the pair this cycle
- op_code  in  8  opcode field
- op_value  in  8  value/operand field
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  8  write address
- mem_wdata  out  16  encoded instruction word
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end
- overflow  out  1  sticky; write address wrapped past 255

Function
REQ-003 Encoding SHALL be mem_wdata[15:8]=op_code, mem_wdata[7:0]=op_value, the exact inverse of the ID-stage field split.
REQ-004 Handshake: a pair SHALL be accepted on a rising edge where op_valid and op_ready are both 1. Data is sampled only then.
REQ-005 op_ready SHALL be 1 only in ACTIVE, with the FIFO not full, accepted<length and halt_program=0. It is combinational from registered state and halt_program only, never from op_valid.
REQ-006 Accepted pairs SHALL enter a 4-entry FIFO. Push and pop in the same cycle SHALL be allowed.
REQ-007 When the FIFO is non-empty and halt_program=0, one entry SHALL pop per edge. mem_we, mem_addr and mem_wdata are registered and show that entry with mem_we=1 for exactly the cycle after the pop edge.
REQ-008 Latency: a pair accepted at edge N into an empty FIFO SHALL drive mem_we=1 in the cycle after edge N+1. Sustained throughput SHALL be 1 word/cycle.
REQ-009 mem_addr SHALL equal base_addr plus the number of words already written, modulo 256. On a 255->0 wrap, overflow SHALL set and hold until the next accepted start.
REQ-010 mem_we SHALL be 0 in every cycle without a pop. mem_addr and mem_wdata hold their last values when mem_we=0.
REQ-011 FSM states: IDLE, ACTIVE, DRAIN, DONE.
- IDLE: start latches base_addr/length, clears counters and overflow; length=0 goes to DONE, otherwise ACTIVE.
- ACTIVE: moves to DRAIN on the edge where accepted reaches length.
- DRAIN: moves to DONE on the edge where written reaches length.
- DONE: lasts one cycle, done=1, then IDLE.
REQ-012 busy SHALL be 1 in ACTIVE and DRAIN. start outside IDLE SHALL be ignored.
REQ-013 While halt_program=1: no accept, no pop, mem_we=0, FSM, counters and FIFO held. Operation resumes the cycle after it deasserts, with no loss or duplication.
REQ-014 Counters SHALL be 9 bits so that length=255 completes without aliasing.

Reset
REQ-015 rst=0 SHALL asynchronously force IDLE, empty FIFO, zero counters, and mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, op_ready=0.
REQ-016 Reset mid-session SHALL abandon the session: no further mem_we until a new start, and discarded FIFO contents are never written.

Structure
REQ-017 Package enc_pkg SHALL hold the FSM state enum, OP_W=8, IR_W=16, ADDR_W=8 and FIFO_DEPTH=4.
REQ-018 The FIFO SHALL be a sub-module, instr_fifo, with push/pop/full/empty, parameterised by depth and width.

Verification
REQ-019 Basic: base=0x10, length=3, op_valid held high with pairs (0x01,0xAA),(0x02,0xBB),(0x03,0xCC) -> writes 0x01AA@0x10, 0x02BB@0x11, 0x03CC@0x12 on consecutive cycles, then done pulses once and busy drops.
REQ-020 Wrap: base=0xFE, length=3 -> addresses 0xFE, 0xFF, 0x00 and overflow=1 after the third write; the next start clears overflow.
REQ-021 Backpressure: hold halt_program high for 5 cycles mid-session with op_valid=1 -> op_ready=0 and mem_we=0 throughout; after release, all 8 words of length=8 are written in order, none missing or duplicated.
REQ-022 Zero length: start with length=0 -> done pulses on the second cycle, no mem_we, op_ready never 1.
REQ-023 Reset mid-session: length=6, assert rst after 2 accepts -> all outputs 0 immediately; with no new start, mem_we stays 0 for 20 cycles.
REQ-024 Ignored start: a start pulse with base=0x40 during ACTIVE -> no effect; addresses continue from the original base.
